cond_exec_stage: RTL and testbench

Decode-to-execute pipeline boundary for the ARM pipelined core. It registers the decoder's control bundle and condition field into the execute stage and holds the architectural NZCV flags. It evaluates the instruction's 4-bit condition against those flags and gates every architectural side effect (register write, memory write, PC write, branch, flag write) with the result. It also keeps a saturating count of squashed instructions.

---
 rtl/cond_exec_stage.sv | 207 ++++++++++++++++++++
 tb/tb_cond_exec_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - decode-to-execute register with condition evaluation and flag state
//
// Registers the decoder control bundle and condition field into the execute
// stage, holds the architectural NZCV flags, evaluates the instruction
// condition against them and gates every architectural side effect with the
// result. Also keeps a saturating count of squashed (condition-failed)
// instructions.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   FlushE              load a bubble into the execute register this edge
//   CondD               condition field of the decode-stage instruction
//   PCSD .. BLControlD  decoder single-bit controls
//   ALUControlD         decoder ALU operation
//   FlagWD              [1] write N,Z ; [0] write C,V
//   ALUFlagsE           {N,Z,C,V} from the ALU for the instruction in E
//   PCSrcE, RegWriteE, MemWriteE, BranchTakenE   condition-gated side effects
//   MemtoRegE, ALUSrcE, ByteEnableE, BLControlE, ALUControlE   registered controls
//   CondExE             condition passed and E holds a valid instruction
//   FlagsQ              current {N,Z,C,V}
//   SquashCnt           saturating count of condition-failed instructions

module cond_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlushE,
  input  logic [3:0]       CondD,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemtoRegD,
  input  logic             MemWD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             ByteEnableD,
  input  logic             BLControlD,
  input  logic [3:0]       ALUControlD,
  input  logic [1:0]       FlagWD,
  input  logic [3:0]       ALUFlagsE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchTakenE,
  output logic             MemtoRegE,
  output logic             ALUSrcE,
  output logic             ByteEnableE,
  output logic             BLControlE,
  output logic [3:0]       ALUControlE,
  output logic             CondExE,
  output logic [3:0]       FlagsQ,
  output logic [CNT_W-1:0] SquashCnt
);

  localparam logic [3:0] COND_AL = 4'b1110;

  // Execute-stage register contents
  logic             valid_q,    valid_d;
  logic [3:0]       cond_q,     cond_d;
  logic             pcs_q,      pcs_d;
  logic             regw_q,     regw_d;
  logic             memtoreg_q, memtoreg_d;
  logic             memw_q,     memw_d;
  logic             branch_q,   branch_d;
  logic             alusrc_q,   alusrc_d;
  logic             byteen_q,   byteen_d;
  logic             bl_q,       bl_d;
  logic [3:0]       aluctrl_q,  aluctrl_d;
  logic [1:0]       flagw_q,    flagw_d;

  // Architectural state
  logic [3:0]       flags_q,    flags_d;
  logic [CNT_W-1:0] squash_q,   squash_d;

  logic             cond_pass;
  logic             cond_ex;
  logic             flag_n, flag_z, flag_c, flag_v;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition evaluation against the committed flags only; flags produced by
  // the instruction currently in E are not forwarded to itself.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond_q)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex = valid_q & cond_pass;

  // Next E contents: the flush wins over an incoming instruction.
  always_comb begin
    valid_d    = 1'b1;
    cond_d     = CondD;
    pcs_d      = PCSD;
    regw_d     = RegWD;
    memtoreg_d = MemtoRegD;
    memw_d     = MemWD;
    branch_d   = BranchD;
    alusrc_d   = ALUSrcD;
    byteen_d   = ByteEnableD;
    bl_d       = BLControlD;
    aluctrl_d  = ALUControlD;
    flagw_d    = FlagWD;
    if (FlushE) begin
      valid_d    = 1'b0;
      cond_d     = COND_AL;
      pcs_d      = 1'b0;
      regw_d     = 1'b0;
      memtoreg_d = 1'b0;
      memw_d     = 1'b0;
      branch_d   = 1'b0;
      alusrc_d   = 1'b0;
      byteen_d   = 1'b0;
      bl_d       = 1'b0;
      aluctrl_d  = 4'b0000;
      flagw_d    = 2'b00;
    end
  end

  // Flag update: the two halves are enabled independently so logical ops can
  // update N,Z while preserving C,V.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (flagw_q[1]) flags_d[3:2] = ALUFlagsE[3:2];
      if (flagw_q[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
  end

  // Squash counter saturates rather than wrapping.
  always_comb begin
    squash_d = squash_q;
    if (valid_q && !cond_pass && (squash_q != {CNT_W{1'b1}})) begin
      squash_d = squash_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      cond_q     <= COND_AL;
      pcs_q      <= 1'b0;
      regw_q     <= 1'b0;
      memtoreg_q <= 1'b0;
      memw_q     <= 1'b0;
      branch_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      byteen_q   <= 1'b0;
      bl_q       <= 1'b0;
      aluctrl_q  <= 4'b0000;
      flagw_q    <= 2'b00;
      flags_q    <= 4'b0000;
      squash_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      cond_q     <= cond_d;
      pcs_q      <= pcs_d;
      regw_q     <= regw_d;
      memtoreg_q <= memtoreg_d;
      memw_q     <= memw_d;
      branch_q   <= branch_d;
      alusrc_q   <= alusrc_d;
      byteen_q   <= byteen_d;
      bl_q       <= bl_d;
      aluctrl_q  <= aluctrl_d;
      flagw_q    <= flagw_d;
      flags_q    <= flags_d;
      squash_q   <= squash_d;
    end
  end

  assign PCSrcE       = pcs_q    & cond_ex;
  assign RegWriteE    = regw_q   & cond_ex;
  assign MemWriteE    = memw_q   & cond_ex;
  assign BranchTakenE = branch_q & cond_ex;

  assign MemtoRegE    = memtoreg_q;
  assign ALUSrcE      = alusrc_q;
  assign ByteEnableE  = byteen_q;
  assign BLControlE   = bl_q;
  assign ALUControlE  = aluctrl_q;

  assign CondExE      = cond_ex;
  assign FlagsQ       = flags_q;
  assign SquashCnt    = squash_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - scoreboard bench for cond_exec_stage
module tb_cond_exec_stage;

  localparam int CNT_W = 4;
  localparam int OW    = 17 + CNT_W;

  typedef struct packed {
    logic       pcs, regw, memtoreg, memw, branch, alusrc, byteen, bl;
    logic [3:0] aluctrl;
    logic [1:0] flagw;
    logic [3:0] cond;
  } dinst_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  dinst_t           d_in = '0;
  logic [3:0]       alu_flags = 4'b0000;

  logic             PCSrcE, RegWriteE, MemWriteE, BranchTakenE;
  logic             MemtoRegE, ALUSrcE, ByteEnableE, BLControlE;
  logic [3:0]       ALUControlE;
  logic             CondExE;
  logic [3:0]       FlagsQ;
  logic [CNT_W-1:0] SquashCnt;

  cond_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .FlushE(flush), .CondD(d_in.cond),
    .PCSD(d_in.pcs), .RegWD(d_in.regw), .MemtoRegD(d_in.memtoreg),
    .MemWD(d_in.memw), .BranchD(d_in.branch), .ALUSrcD(d_in.alusrc),
    .ByteEnableD(d_in.byteen), .BLControlD(d_in.bl),
    .ALUControlD(d_in.aluctrl), .FlagWD(d_in.flagw), .ALUFlagsE(alu_flags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
    .ByteEnableE(ByteEnableE), .BLControlE(BLControlE),
    .ALUControlE(ALUControlE), .CondExE(CondExE), .FlagsQ(FlagsQ),
    .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the instruction sitting in E, flags, squash count
  dinst_t           m_e;
  logic             m_valid;
  logic [3:0]       m_flags;
  int               m_cnt;
  logic [OW-1:0]    exp_q[$];

  function automatic logic [OW-1:0] dut_vec();
    return {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE,
            ByteEnableE, BLControlE, ALUControlE, CondExE, FlagsQ, SquashCnt};
  endfunction

  // Conditions come in complementary pairs: the upper three bits pick a test,
  // the low bit inverts it; code 1110 is always and 1111 never.
  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    if (code == 4'b1110) return 1'b1;
    if (code == 4'b1111) return 1'b0;
    case (code[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      default: r = !z && (n == v);
    endcase
    return code[0] ? !r : r;
  endfunction

  function automatic logic [OW-1:0] model_vec();
    bit ok;
    ok = m_valid && cond_ok(m_e.cond, m_flags);
    return {m_e.pcs & ok, m_e.regw & ok, m_e.memw & ok, m_e.branch & ok,
            m_e.memtoreg, m_e.alusrc, m_e.byteen, m_e.bl, m_e.aluctrl,
            ok, m_flags, m_cnt[CNT_W-1:0]};
  endfunction

  task automatic model_reset();
    m_e       = '0;
    m_e.cond  = 4'b1110;
    m_valid   = 1'b0;
    m_flags   = 4'b0000;
    m_cnt     = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances over the same edge and the
  // expected E-stage outputs are queued for the monitor.
  task automatic step(input dinst_t d, input logic fl, input logic [3:0] alu);
    bit ok;
    @(negedge clk);
    #1;
    reset     = 1'b1;
    d_in      = d;
    flush     = fl;
    alu_flags = alu;
    ok = m_valid && cond_ok(m_e.cond, m_flags);
    if (ok) begin
      if (m_e.flagw[1]) m_flags[3:2] = alu[3:2];
      if (m_e.flagw[0]) m_flags[1:0] = alu[1:0];
    end else if (m_valid && m_cnt < (1 << CNT_W) - 1) begin
      m_cnt++;
    end
    if (fl) begin
      m_e = '0;
      m_e.cond = 4'b1110;
      m_valid = 1'b0;
    end else begin
      m_e = d;
      m_valid = 1'b1;
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic observe();
    @(posedge clk);
    #1;
  endtask

  function automatic dinst_t inst(input logic [3:0] cond, input logic regw, input logic [1:0] fw);
    dinst_t d;
    d = '0;
    d.cond = cond;
    d.regw = regw;
    d.flagw = fw;
    return d;
  endfunction

  function automatic dinst_t rand_inst();
    logic [31:0] r;
    r = $urandom();
    return r[17:0];
  endfunction

  // Monitor: every negedge with an outstanding expectation compares the DUT
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e, a;
      e = exp_q.pop_front();
      a = dut_vec();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  initial begin
    logic [3:0]       f_saved;
    logic [CNT_W-1:0] c_saved;
    dinst_t           d;
    model_reset();

    // Reset held with random inputs and clock running
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      d_in = rand_inst();
      flush = 1'b0;
      alu_flags = 4'($urandom());
      observe();
      check("reset_outputs", 32'(dut_vec()), 32'd0);
    end

    // First edge after release loads D
    d = inst(4'b1110, 1'b1, 2'b00);
    d.memtoreg = 1'b1;
    step(d, 1'b0, 4'b0000);
    observe();
    check("release_load", {31'd0, RegWriteE}, 32'd1);

    // SUBS then EQ
    step(inst(4'b1110, 1'b0, 2'b11), 1'b0, 4'b0000);
    step(inst(4'b0000, 1'b1, 2'b00), 1'b0, 4'b0100);
    observe();
    check("subs_flags", {28'd0, FlagsQ}, 32'h4);
    check("eq_regwrite", {31'd0, RegWriteE}, 32'd1);

    // SUBS then NE: squashed
    step(inst(4'b1110, 1'b0, 2'b11), 1'b0, 4'b0000);
    step(inst(4'b0001, 1'b1, 2'b00), 1'b0, 4'b0100);
    observe();
    check("ne_regwrite", {31'd0, RegWriteE}, 32'd0);
    c_saved = SquashCnt;
    step(inst(4'b1110, 1'b0, 2'b00), 1'b1, 4'b0000);
    observe();
    check("ne_squash_inc", 32'(SquashCnt), 32'(c_saved) + 1);

    // Partial flag write
    step(inst(4'b1110, 1'b0, 2'b11), 1'b0, 4'b0000);
    step(inst(4'b1110, 1'b0, 2'b10), 1'b0, 4'b1111);
    observe();
    check("flags_all_set", {28'd0, FlagsQ}, 32'hf);
    step(inst(4'b1110, 1'b0, 2'b00), 1'b1, 4'b0000);
    observe();
    check("partial_write", {28'd0, FlagsQ}, 32'h3);

    // Flush discards a D-stage branch
    f_saved = FlagsQ;
    c_saved = SquashCnt;
    d = inst(4'b1110, 1'b0, 2'b11);
    d.branch = 1'b1;
    d.pcs = 1'b1;
    step(d, 1'b1, 4'b1010);
    observe();
    check("flush_branch", {30'd0, BranchTakenE, PCSrcE}, 32'd0);
    check("flush_flags", {28'd0, FlagsQ}, 32'(f_saved));
    check("flush_cnt", 32'(SquashCnt), 32'(c_saved));

    // Condition sweep: load flags, then evaluate each code
    for (int code = 0; code < 16; code++) begin
      for (int f = 0; f < 16; f++) begin
        step(inst(4'b1110, 1'b0, 2'b11), 1'b0, 4'b0000);
        step(inst(4'(code), 1'b1, 2'b00), 1'b0, 4'(f));
        observe();
        if (code == 15) check("cond_nv", {31'd0, CondExE}, 32'd0);
        if (code == 14) check("cond_al", {31'd0, CondExE}, 32'd1);
      end
    end

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(rand_inst(), ($urandom_range(7) == 0), 4'($urandom()));
    end

    // Async reset to start saturation from zero
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_mid1", 32'(dut_vec()), 32'd0);

    for (int i = 0; i < (1 << CNT_W) - 2; i++) step(inst(4'b1111, 1'b1, 2'b11), 1'b0, 4'($urandom()));
    step(inst(4'b1110, 1'b0, 2'b00), 1'b1, 4'b0000);
    observe();
    check("cnt_preload", 32'(SquashCnt), 32'((1 << CNT_W) - 2));
    for (int i = 0; i < 3; i++) step(inst(4'b1111, 1'b1, 2'b00), 1'b0, 4'b0000);
    step(inst(4'b1110, 1'b0, 2'b00), 1'b1, 4'b0000);
    observe();
    check("cnt_saturate", 32'(SquashCnt), 32'((1 << CNT_W) - 1));

    // Flag-writing instruction in flight, then reset between edges
    step(inst(4'b1110, 1'b0, 2'b11), 1'b0, 4'b0000);
    step(inst(4'b1110, 1'b1, 2'b11), 1'b0, 4'b1101);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_cnt", 32'(SquashCnt), 32'd0);
    check("async_flags", {28'd0, FlagsQ}, 32'd0);
    check("async_outputs", 32'(dut_vec()), 32'd0);
    observe();
    check("reset_hold", 32'(dut_vec()), 32'd0);

    step(inst(4'b1110, 1'b1, 2'b00), 1'b0, 4'b0000);
    step(inst(4'b1110, 1'b0, 2'b00), 1'b1, 4'b0000);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
